// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: drives the 10 ms tick generator and keeps a BCD mm:ss:cc count.
// Optional lap capture is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int MIN_MAX = 59
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic        iCLEAR,
  input  logic        iLAP,
  input  logic        iGEN_10MS,
  output logic        oCK_RUN,
  output logic        oCK_RST,
  output logic [7:0]  oCS,
  output logic [7:0]  oSEC,
  output logic [7:0]  oMIN,
  output logic [23:0] oLAP,
  output logic        oLAP_VLD,
  output logic        oRUNNING,
  output logic        oOVF
);

  // state | meaning
  // IDLE  | generator held in reset, counts cleared
  // RUN   | generator running, ticks accepted
  // PAUSE | generator halted with prescaler phase kept, ticks discarded
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] MIN_LAST = 8'(((MIN_MAX / 10) * 16) + (MIN_MAX % 10));

  state_t     state_q, state_d;
  logic [7:0] cs_q, cs_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       ovf_q, ovf_d;
  logic       tick_acc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign tick_acc = iGEN_10MS && (state_q == S_RUN);

  always_comb begin
    cs_d  = cs_q;
    sec_d = sec_q;
    min_d = min_q;
    ovf_d = 1'b0;
    if (tick_acc) begin
      if (cs_q == 8'h99) begin
        cs_d = 8'h00;
        if (sec_q == 8'h59) begin
          sec_d = 8'h00;
          if (min_q == MIN_LAST) begin
            min_d = 8'h00;
            ovf_d = 1'b1;
          end else begin
            min_d = bcd_inc(min_q);
          end
        end else begin
          sec_d = bcd_inc(sec_q);
        end
      end else begin
        cs_d = bcd_inc(cs_q);
      end
    end
  end

  // Stop has priority in RUN so a simultaneous start/stop always pauses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (iSTOP) state_d = S_PAUSE;
      S_IDLE,
      S_PAUSE: if (iSTART) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET || iCLEAR) begin
      state_q <= S_IDLE;
      cs_q    <= 8'h00;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oCK_RUN  = (state_q == S_RUN);
  assign oCK_RST  = (state_q == S_IDLE);
  assign oRUNNING = oCK_RUN;
  assign oCS      = cs_q;
  assign oSEC     = sec_q;
  assign oMIN     = min_q;
  assign oOVF     = ovf_q;

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_q;
  logic        lap_vld_q;

  // Capture uses the pre-increment registers, so a coincident tick is not seen.
  always_ff @(posedge iCLK) begin
    if (iRESET || iCLEAR) begin
      lap_q     <= 24'h0;
      lap_vld_q <= 1'b0;
    end else if (iLAP && (state_q != S_IDLE)) begin
      lap_q     <= {min_q, sec_q, cs_q};
      lap_vld_q <= 1'b1;
    end
  end

  assign oLAP     = lap_q;
  assign oLAP_VLD = lap_vld_q;
`else
  logic unused_lap;
  assign unused_lap = iLAP;
  assign oLAP       = 24'h0;
  assign oLAP_VLD   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a decimal reference model and expectation queue.
// Runs with MIN_MAX=1 so the minute wrap is reachable; honours STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  localparam int MIN_MAX = 1;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b0, iSTART = 1'b0, iSTOP = 1'b0, iCLEAR = 1'b0, iLAP = 1'b0;
  logic        iGEN_10MS = 1'b0;
  logic        oCK_RUN, oCK_RST, oLAP_VLD, oRUNNING, oOVF;
  logic [7:0]  oCS, oSEC, oMIN;
  logic [23:0] oLAP;

  stopwatch_ctrl #(.MIN_MAX(MIN_MAX)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iSTOP(iSTOP), .iCLEAR(iCLEAR),
    .iLAP(iLAP), .iGEN_10MS(iGEN_10MS), .oCK_RUN(oCK_RUN), .oCK_RST(oCK_RST),
    .oCS(oCS), .oSEC(oSEC), .oMIN(oMIN), .oLAP(oLAP), .oLAP_VLD(oLAP_VLD),
    .oRUNNING(oRUNNING), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        run, rst, ovf, vld;
    logic [7:0]  cs, sec, mn;
    logic [23:0] lap;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;

  // Reference model: plain decimal counters, state 0=IDLE 1=RUN 2=PAUSE.
  int          m_st = 0, m_cs = 0, m_sec = 0, m_min = 0;
  logic        m_ovf = 1'b0, m_vld = 1'b0;
  logic [23:0] m_lap = 24'h0;

  bit d_rst, d_start, d_stop, d_clear, d_lap, d_tick;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_step();
    bit acc;
    if (d_rst || d_clear) begin
      m_st = 0; m_cs = 0; m_sec = 0; m_min = 0;
      m_ovf = 1'b0; m_vld = 1'b0; m_lap = 24'h0;
    end else begin
      acc = d_tick && (m_st == 1);
      if (LAP_ON && d_lap && (m_st != 0)) begin
        m_lap = {bcd(m_min), bcd(m_sec), bcd(m_cs)};
        m_vld = 1'b1;
      end
      m_ovf = 1'b0;
      if (acc) begin
        m_cs++;
        if (m_cs == 100) begin m_cs = 0; m_sec++; end
        if (m_sec == 60) begin m_sec = 0; m_min++; end
        if (m_min > MIN_MAX) begin m_min = 0; m_ovf = 1'b1; end
      end
      if (m_st == 1 && d_stop) m_st = 2;
      else if (m_st != 1 && d_start) m_st = 1;
    end
  endtask

  task automatic cmp(input string tag, input string nm, input logic [23:0] obs, input logic [23:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, nm, obs, expv);
    end
  endtask

  task automatic step(input bit chk, input string tag);
    exp_t e, g;
    string t;
    @(negedge iCLK);
    iRESET = d_rst; iSTART = d_start; iSTOP = d_stop;
    iCLEAR = d_clear; iLAP = d_lap; iGEN_10MS = d_tick;
    model_step();
    if (chk) begin
      e.run = (m_st == 1); e.rst = (m_st == 0); e.ovf = m_ovf; e.vld = m_vld;
      e.cs = bcd(m_cs); e.sec = bcd(m_sec); e.mn = bcd(m_min); e.lap = m_lap;
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    d_rst = 0; d_start = 0; d_stop = 0; d_clear = 0; d_lap = 0; d_tick = 0;
    @(posedge iCLK);
    #1;
    if (chk) begin
      g = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "ck_run",  24'(oCK_RUN),  24'(g.run));
      cmp(t, "ck_rst",  24'(oCK_RST),  24'(g.rst));
      cmp(t, "running", 24'(oRUNNING), 24'(g.run));
      cmp(t, "cs",      24'(oCS),      24'(g.cs));
      cmp(t, "sec",     24'(oSEC),     24'(g.sec));
      cmp(t, "min",     24'(oMIN),     24'(g.mn));
      cmp(t, "ovf",     24'(oOVF),     24'(g.ovf));
      cmp(t, "lap",     oLAP,          g.lap);
      cmp(t, "lap_vld", 24'(oLAP_VLD), 24'(g.vld));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      d_tick = 1;
      step(0, "");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, "");
  endtask

  initial begin
    d_rst = 1; step(0, "");
    d_rst = 1; step(1, "reset");
    ticks(50);
    step(1, "idle_ticks");

    d_start = 1; step(1, "start");
    ticks(150);
    step(1, "t150");
    ticks(5849);
    step(1, "at_00_59_99");
    d_tick = 1; step(1, "to_01_00_00");
    ticks(5999);
    step(1, "at_01_59_99");
    d_tick = 1; step(1, "min_wrap");
    step(1, "ovf_one_cycle");

    d_clear = 1; step(1, "clear");
    d_start = 1; step(1, "start2");
    ticks(5);
    d_stop = 1; d_tick = 1; step(1, "stop_tick");
    ticks(20);
    step(1, "pause_ticks");
    d_start = 1; step(1, "resume");
    d_tick = 1; step(1, "resume_tick");
    d_start = 1; d_stop = 1; step(1, "both_in_run");
    d_start = 1; d_stop = 1; step(1, "both_in_pause");
    d_start = 1; step(1, "start_in_run");
    d_clear = 1; d_tick = 1; step(1, "clear_tick");
    d_stop = 1; step(1, "stop_in_idle");

    d_start = 1; step(0, "");
    ticks(41);
    step(1, "at_41");
    d_lap = 1; d_tick = 1; step(1, "lap_tick");
    ticks(7);
    d_stop = 1; step(0, "");
    d_lap = 1; step(1, "lap_pause");
    d_clear = 1; step(1, "lap_clear");
    d_lap = 1; step(1, "lap_idle");

    d_start = 1; step(0, "");
    ticks(3);
    d_rst = 1; d_tick = 1; d_lap = 1; step(1, "reset_mid_run");
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
